// File: rtl/cavlc_level_enc_mlane_pkg.sv
// Shared constants and FSM state type for the multi-lane CAVLC level encoder.
//   SUFFIX_W    level_suffix field width (escape suffix is always this long)
//   PREFIX_W    level_prefix field width
//   LEN_W       suffix bit-count field width
//   SL_W        suffixLength register width
//   PREFIX_ESC  escape prefix value
//   SL_MAX      suffixLength ceiling
//   SL0_SHORT   first code needing the 4-bit suffix at suffixLength 0
//   SL0_ESC     first escape code at suffixLength 0
package cavlc_level_enc_mlane_pkg;
    localparam int SUFFIX_W   = 12;
    localparam int PREFIX_W   = 5;
    localparam int LEN_W      = 4;
    localparam int SL_W       = 3;
    localparam int PREFIX_ESC = 15;
    localparam int SL_MAX     = 6;
    localparam int SL0_SHORT  = 14;
    localparam int SL0_ESC    = 30;
    localparam int SUFFIX_SAT = (1 << SUFFIX_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ZERO = 2'd2
    } state_t;
endpackage

// File: rtl/cavlc_level_enc_mlane_lane.sv
// Combinational single-level coder: maps one signed level and the incoming
// suffixLength to level_prefix / level_suffix and the next suffixLength.
//   level      signed coefficient (RES_WIDTH bits)
//   sl_in      suffixLength in force for this level
//   first      first non-trailing-one level of a block with T1<3
//   prefix     level_prefix 0..15
//   suffix     level_suffix, right-aligned
//   suffix_len suffix bit count 0..12
//   ovf        escape remainder saturated
//   sl_out     suffixLength after this level
module cavlc_level_lane
    import cavlc_level_enc_mlane_pkg::*;
#(
    parameter int RES_WIDTH = 16
) (
    input  logic [RES_WIDTH-1:0] level,
    input  logic [SL_W-1:0]      sl_in,
    input  logic                 first,
    output logic [PREFIX_W-1:0]  prefix,
    output logic [SUFFIX_W-1:0]  suffix,
    output logic [LEN_W-1:0]     suffix_len,
    output logic                 ovf,
    output logic [SL_W-1:0]      sl_out
);
    localparam int CW = RES_WIDTH + 2;

    logic                 neg;
    logic                 esc;
    logic [RES_WIDTH:0]   mag;
    logic [CW-1:0]        code;
    logic [CW-1:0]        lim;
    logic [CW-1:0]        mask;
    logic [CW-1:0]        esc_base;
    logic [CW-1:0]        rem;
    logic [CW-1:0]        grow_thr;
    logic [PREFIX_W-1:0]  shifted;
    logic [SL_W-1:0]      sl_eff;

    always_comb begin
        prefix     = '0;
        suffix     = '0;
        suffix_len = '0;
        ovf        = 1'b0;
        esc        = 1'b0;

        // One extra magnitude bit keeps -2^(RES_WIDTH-1) exact.
        neg  = level[RES_WIDTH-1];
        mag  = neg ? ({1'b0, ~level} + {{RES_WIDTH{1'b0}}, 1'b1}) : {1'b0, level};
        code = {mag, 1'b0} - (neg ? CW'(1) : CW'(2)) - (first ? CW'(2) : CW'(0));

        lim      = CW'(PREFIX_ESC) << sl_in;
        mask     = (CW'(1) << sl_in) - CW'(1);
        shifted  = PREFIX_W'(code >> sl_in);
        esc_base = lim;

        if (sl_in == '0) begin
            esc_base = CW'(SL0_ESC);
            if (code < CW'(SL0_SHORT)) begin
                prefix = code[PREFIX_W-1:0];
            end else if (code < CW'(SL0_ESC)) begin
                prefix     = PREFIX_W'(SL0_SHORT);
                suffix     = SUFFIX_W'(code - CW'(SL0_SHORT));
                suffix_len = LEN_W'(4);
            end else begin
                esc = 1'b1;
            end
        end else if (code < lim) begin
            prefix     = shifted;
            suffix     = SUFFIX_W'(code & mask);
            suffix_len = LEN_W'(sl_in);
        end else begin
            esc = 1'b1;
        end

        rem = code - esc_base;
        if (esc) begin
            prefix     = PREFIX_W'(PREFIX_ESC);
            suffix_len = LEN_W'(SUFFIX_W);
            if (rem > CW'(SUFFIX_SAT)) begin
                suffix = '1;
                ovf    = 1'b1;
            end else begin
                suffix = rem[SUFFIX_W-1:0];
            end
        end

        // Growth test uses the already-bumped suffixLength.
        sl_eff   = (sl_in == '0) ? SL_W'(1) : sl_in;
        grow_thr = CW'(3) << (sl_eff - SL_W'(1));
        sl_out   = sl_eff;
        if (({1'b0, mag} > grow_thr) && (sl_eff < SL_W'(SL_MAX)))
            sl_out = sl_eff + SL_W'(1);
    end
endmodule

// File: rtl/cavlc_level_enc_mlane.sv
// Multi-lane CAVLC level encoder. Takes a block header (TotalCoeff,
// TrailingOnes) then ceil(TC/LANES) beats of levels in reverse scan order and
// produces one registered output beat per input beat.
//   clk, rst_n                clock, synchronous active-low reset
//   blk_valid/blk_ready       header handshake (accepted only in IDLE)
//   total_coeff, trail_ones   block header fields
//   in_valid/in_ready/in_level level beat handshake, LANES levels per beat
//   out_valid/out_ready       output beat handshake
//   out_en                    lanes carrying a level code
//   out_prefix/out_suffix/out_suffix_len  per-lane level code fields
//   out_t1_sign/out_t1_len    trailing-one signs (on the beat with the last one)
//   out_last                  final beat of block
//   out_ovf                   sticky per block: a suffix saturated
module cavlc_level_enc_mlane
    import cavlc_level_enc_mlane_pkg::*;
#(
    parameter int RES_WIDTH = 16,
    parameter int LANES     = 2,
    parameter int MAX_COEFF = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         blk_valid,
    output logic                         blk_ready,
    input  logic [4:0]                   total_coeff,
    input  logic [1:0]                   trail_ones,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*RES_WIDTH-1:0]   in_level,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES-1:0]             out_en,
    output logic [LANES*PREFIX_W-1:0]    out_prefix,
    output logic [LANES*SUFFIX_W-1:0]    out_suffix,
    output logic [LANES*LEN_W-1:0]       out_suffix_len,
    output logic [2:0]                   out_t1_sign,
    output logic [1:0]                   out_t1_len,
    output logic                         out_last,
    output logic                         out_ovf
);
    localparam int MAX_BEATS = (MAX_COEFF + LANES - 1) / LANES;
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

    state_t              state, state_nxt;
    logic [4:0]          tc_r;
    logic [1:0]          t1_r;
    logic [BEAT_W-1:0]   nbeats_r, beat_r, nbeats;
    logic [5:0]          nb_sum;
    logic [SL_W-1:0]     sl_r, sl0;
    logic [2:0]          t1_acc, t1_nxt;
    logic                t1_hit;
    logic                hdr_fire, in_fire, out_free, zero_load, beat_ovf, last_beat;

    logic [7:0]          lane_idx    [LANES];
    logic [PREFIX_W-1:0] lane_prefix [LANES];
    logic [SUFFIX_W-1:0] lane_suffix [LANES];
    logic [LEN_W-1:0]    lane_len    [LANES];
    logic [SL_W-1:0]     lane_sl     [LANES];
    logic [SL_W-1:0]     sl_chain    [LANES+1];
    logic [LANES-1:0]    lane_t1, lane_lvl, lane_first, lane_ovf;

    // suffixLength ripples through the lanes; non-level lanes pass it through.
    assign sl_chain[0] = sl_r;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_idx[g]   = 8'(beat_r) * 8'(LANES) + 8'(g);
        assign lane_t1[g]    = (lane_idx[g] < {3'b0, tc_r}) && (lane_idx[g] < {6'b0, t1_r});
        assign lane_lvl[g]   = (lane_idx[g] < {3'b0, tc_r}) && !(lane_idx[g] < {6'b0, t1_r});
        assign lane_first[g] = (lane_idx[g] == {6'b0, t1_r}) && (t1_r != 2'd3);

        cavlc_level_lane #(.RES_WIDTH(RES_WIDTH)) u_lane (
            .level      (in_level[g*RES_WIDTH +: RES_WIDTH]),
            .sl_in      (sl_chain[g]),
            .first      (lane_first[g]),
            .prefix     (lane_prefix[g]),
            .suffix     (lane_suffix[g]),
            .suffix_len (lane_len[g]),
            .ovf        (lane_ovf[g]),
            .sl_out     (lane_sl[g])
        );

        assign sl_chain[g+1] = lane_lvl[g] ? lane_sl[g] : sl_chain[g];
    end

    // Trailing-one signs accumulate across beats, earliest coefficient in the MSB.
    always_comb begin
        t1_nxt = t1_acc;
        t1_hit = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_t1[i]) begin
                t1_nxt = {t1_nxt[1:0], in_level[i*RES_WIDTH + RES_WIDTH - 1]};
                if (lane_idx[i] == ({6'b0, t1_r} - 8'd1))
                    t1_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        blk_ready = (state == ST_IDLE);
        out_free  = !out_valid || out_ready;
        in_ready  = (state == ST_RUN) && (beat_r != nbeats_r) && out_free;
        hdr_fire  = blk_valid && blk_ready;
        in_fire   = in_valid && in_ready;
        zero_load = (state == ST_ZERO) && !out_valid;
        beat_ovf  = |(lane_ovf & lane_lvl);
        last_beat = ((beat_r + BEAT_W'(1)) == nbeats_r);
        nb_sum    = {1'b0, total_coeff} + 6'(LANES - 1);
        nbeats    = BEAT_W'(nb_sum / 6'(LANES));
        sl0       = ((total_coeff > 5'd10) && (trail_ones < 2'd3)) ? SL_W'(1) : SL_W'(0);

        case (state)
            ST_IDLE: if (hdr_fire) state_nxt = (total_coeff == '0) ? ST_ZERO : ST_RUN;
            ST_RUN:  if (out_valid && out_ready && out_last) state_nxt = ST_IDLE;
            ST_ZERO: if (out_valid && out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            tc_r           <= '0;
            t1_r           <= '0;
            nbeats_r       <= '0;
            beat_r         <= '0;
            sl_r           <= '0;
            t1_acc         <= '0;
            out_valid      <= 1'b0;
            out_en         <= '0;
            out_prefix     <= '0;
            out_suffix     <= '0;
            out_suffix_len <= '0;
            out_t1_sign    <= '0;
            out_t1_len     <= '0;
            out_last       <= 1'b0;
            out_ovf        <= 1'b0;
        end else begin
            state <= state_nxt;

            if (hdr_fire) begin
                tc_r     <= total_coeff;
                t1_r     <= trail_ones;
                nbeats_r <= nbeats;
                beat_r   <= '0;
                sl_r     <= sl0;
                t1_acc   <= '0;
                out_ovf  <= 1'b0;
            end

            if (in_fire) begin
                beat_r      <= beat_r + BEAT_W'(1);
                sl_r        <= sl_chain[LANES];
                t1_acc      <= t1_nxt;
                out_valid   <= 1'b1;
                out_last    <= last_beat;
                out_ovf     <= out_ovf | beat_ovf;
                out_t1_len  <= t1_hit ? t1_r : 2'd0;
                out_t1_sign <= t1_hit ? t1_nxt : 3'd0;
                for (int unsigned i = 0; i < LANES; i++) begin
                    out_en[i]                          <= lane_lvl[i];
                    out_prefix[i*PREFIX_W +: PREFIX_W] <= lane_lvl[i] ? lane_prefix[i] : '0;
                    out_suffix[i*SUFFIX_W +: SUFFIX_W] <= lane_lvl[i] ? lane_suffix[i] : '0;
                    out_suffix_len[i*LEN_W +: LEN_W]   <= lane_lvl[i] ? lane_len[i] : '0;
                end
            end else if (zero_load) begin
                out_valid      <= 1'b1;
                out_last       <= 1'b1;
                out_en         <= '0;
                out_prefix     <= '0;
                out_suffix     <= '0;
                out_suffix_len <= '0;
                out_t1_sign    <= '0;
                out_t1_len     <= '0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
